// File: rtl/cmt_ctrl_pkg.sv
// Shared definitions for the commit sequencer: bus widths, the packed commit record
// and the sequencer state encodings.
package cmt_ctrl_pkg;

  localparam int unsigned BUS_64      = 64;
  localparam int unsigned BUS_32      = 32;
  localparam int unsigned RD_W        = 5;
  // rd 5 + wen 1 + wdata 64 + pc 64 + inst 32 + nocmt 1 + skipcmt 1
  localparam int unsigned CMT_ENTRY_W = 168;

  localparam logic [1:0] CMT_ST_RUN    = 2'd0;
  localparam logic [1:0] CMT_ST_DRAIN  = 2'd1;
  localparam logic [1:0] CMT_ST_HALTED = 2'd2;

  typedef enum logic [1:0] {
    StRun    = CMT_ST_RUN,
    StDrain  = CMT_ST_DRAIN,
    StHalted = CMT_ST_HALTED
  } cmt_st_e;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic              rd_wen;
    logic [BUS_64-1:0] rd_wdata;
    logic [BUS_64-1:0] pc;
    logic [BUS_32-1:0] inst;
    logic              nocmt;
    logic              skipcmt;
  } cmt_entry_t;

endpackage

// File: rtl/cmt_fifo.sv
// Synchronous FIFO holding commit records.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (pointers and count only)
//   push, din       write request and data; ignored when full
//   pop             read request; ignored when empty
//   dout            head entry (raw storage contents, not gated when empty)
//   full, empty     occupancy flags derived from the registered count
//   count           registered occupancy, 0..Depth
module cmt_fifo #(
  parameter int unsigned Width = 168,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         din,
  output logic [Width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne  = 1;
  localparam logic [PtrW:0]   CntOne  = 1;
  localparam logic [PtrW:0]   FullCnt = (PtrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cmt_ctrl.sv
// Commit sequencer between writeback and the difftest commit stage.
// Buffers retiring records in a FIFO and replays them over a req/ack handshake,
// drains and freezes the stream on halt, and keeps instruction/cycle counters plus
// a sticky no-commit watchdog.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   i_wb_*, o_wb_ack           writeback record in, accepted when RUN and not full
//   o_cmt_writebacked_req/ack  head record valid / consumed by commit stage
//   o_cmt_*                    head record fields, zero when FIFO empty
//   i_halt_req, o_halted       drain request (RUN only) / drained and frozen
//   o_instr_cnt, o_cycle_cnt   counted commits / active cycles (wrapping)
//   o_hang                     watchdog expired (sticky until reset)
module cmt_ctrl
  import cmt_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wb_req,
  output logic              o_wb_ack,
  input  logic [RD_W-1:0]   i_wb_rd,
  input  logic              i_wb_rd_wen,
  input  logic [BUS_64-1:0] i_wb_rd_wdata,
  input  logic [BUS_64-1:0] i_wb_pc,
  input  logic [BUS_32-1:0] i_wb_inst,
  input  logic              i_wb_nocmt,
  input  logic              i_wb_skipcmt,
  output logic              o_cmt_writebacked_req,
  input  logic              i_cmt_writebacked_ack,
  output logic [RD_W-1:0]   o_cmt_rd,
  output logic              o_cmt_rd_wen,
  output logic [BUS_64-1:0] o_cmt_rd_wdata,
  output logic [BUS_64-1:0] o_cmt_pc,
  output logic [BUS_32-1:0] o_cmt_inst,
  output logic              o_cmt_nocmt,
  output logic              o_cmt_skipcmt,
  input  logic              i_halt_req,
  output logic              o_halted,
  output logic [BUS_64-1:0] o_instr_cnt,
  output logic [BUS_64-1:0] o_cycle_cnt,
  output logic              o_hang
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT) + 1;
  localparam logic [WdW-1:0] WdOne  = 1;
  localparam logic [WdW-1:0] WdHang = WdW'(TIMEOUT - 1);
  localparam logic [WdW-1:0] WdMax  = '1;

  cmt_st_e          state_q, state_d;
  cmt_entry_t       wb_entry, head_raw, head;
  logic [CntW-1:0]  fifo_count;
  logic             fifo_full, fifo_empty;
  logic             push, pop, counted_pop, active;
  logic [BUS_64-1:0] instr_cnt_q, cycle_cnt_q;
  logic [WdW-1:0]   wdog_q, wdog_d;
  logic             hang_q, hang_d;

  // Records are stored exactly as presented, bubble and skip flags included.
  assign wb_entry = '{
    rd:       i_wb_rd,
    rd_wen:   i_wb_rd_wen,
    rd_wdata: i_wb_rd_wdata,
    pc:       i_wb_pc,
    inst:     i_wb_inst,
    nocmt:    i_wb_nocmt,
    skipcmt:  i_wb_skipcmt
  };

  cmt_fifo #(
    .Width (CMT_ENTRY_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wb_entry),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ack depends only on registered occupancy: a pop never frees a slot same-cycle.
  assign o_wb_ack              = (state_q == StRun) & ~fifo_full;
  assign push                  = i_wb_req & o_wb_ack;
  assign o_cmt_writebacked_req = ~fifo_empty;
  assign pop                   = o_cmt_writebacked_req & i_cmt_writebacked_ack;
  assign head                  = fifo_empty ? '0 : head_raw;
  assign counted_pop           = pop & ~head.nocmt;
  assign active                = (state_q != StHalted);

  assign o_cmt_rd       = head.rd;
  assign o_cmt_rd_wen   = head.rd_wen;
  assign o_cmt_rd_wdata = head.rd_wdata;
  assign o_cmt_pc       = head.pc;
  assign o_cmt_inst     = head.inst;
  assign o_cmt_nocmt    = head.nocmt;
  assign o_cmt_skipcmt  = head.skipcmt;

  assign o_halted    = (state_q == StHalted);
  assign o_instr_cnt = instr_cnt_q;
  assign o_cycle_cnt = cycle_cnt_q;
  assign o_hang      = hang_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (i_halt_req) state_d = StDrain;
      StDrain:  if (fifo_count == '0) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  // Watchdog saturates at all-ones so a long stall cannot wrap back below the threshold.
  always_comb begin
    wdog_d = wdog_q;
    if (counted_pop) begin
      wdog_d = '0;
    end else if (active && (wdog_q != WdMax)) begin
      wdog_d = wdog_q + WdOne;
    end
    hang_d = hang_q | (wdog_d == WdHang);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
      wdog_q      <= '0;
      hang_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      hang_q  <= hang_d;
      if (counted_pop) instr_cnt_q <= instr_cnt_q + 64'd1;
      if (active)      cycle_cnt_q <= cycle_cnt_q + 64'd1;
    end
  end

endmodule

// File: tb/tb_cmt_ctrl.sv
module tb_cmt_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned WD_SAT  = (1 << ($clog2(TIMEOUT) + 1)) - 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        nocmt;
    logic        skipcmt;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_req, wb_ack;
  logic [4:0]  wb_rd;
  logic        wb_rd_wen, wb_nocmt, wb_skipcmt;
  logic [63:0] wb_rd_wdata, wb_pc;
  logic [31:0] wb_inst;
  logic        cmt_req, cmt_ack;
  logic [4:0]  cmt_rd;
  logic        cmt_rd_wen, cmt_nocmt, cmt_skipcmt;
  logic [63:0] cmt_rd_wdata, cmt_pc;
  logic [31:0] cmt_inst;
  logic        halt_req, halted, hang;
  logic [63:0] instr_cnt, cycle_cnt;

  cmt_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_wb_req              (wb_req),
    .o_wb_ack              (wb_ack),
    .i_wb_rd               (wb_rd),
    .i_wb_rd_wen           (wb_rd_wen),
    .i_wb_rd_wdata         (wb_rd_wdata),
    .i_wb_pc               (wb_pc),
    .i_wb_inst             (wb_inst),
    .i_wb_nocmt            (wb_nocmt),
    .i_wb_skipcmt          (wb_skipcmt),
    .o_cmt_writebacked_req (cmt_req),
    .i_cmt_writebacked_ack (cmt_ack),
    .o_cmt_rd              (cmt_rd),
    .o_cmt_rd_wen          (cmt_rd_wen),
    .o_cmt_rd_wdata        (cmt_rd_wdata),
    .o_cmt_pc              (cmt_pc),
    .o_cmt_inst            (cmt_inst),
    .o_cmt_nocmt           (cmt_nocmt),
    .o_cmt_skipcmt         (cmt_skipcmt),
    .i_halt_req            (halt_req),
    .o_halted              (halted),
    .o_instr_cnt           (instr_cnt),
    .o_cycle_cnt           (cycle_cnt),
    .o_hang                (hang)
  );

  always #5 clk = ~clk;

  // Reference model: queue of records plus plain counters.
  rec_t            q[$];
  rec_t            cur;
  int              m_st;       // 0 run, 1 drain, 2 halted
  longint unsigned m_instr, m_cycles;
  int unsigned     m_idle;
  bit              m_hang;
  bit              m_pushed;
  int              n_checks = 0;
  int              n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare();
    rec_t h;
    h = (q.size() != 0) ? q[0] : '0;
    check("wb_ack",    64'(wb_ack),       64'(m_st == 0 && q.size() < DEPTH));
    check("cmt_req",   64'(cmt_req),      64'(q.size() != 0));
    check("cmt_pc",    cmt_pc,            h.pc);
    check("cmt_wdata", cmt_rd_wdata,      h.wdata);
    check("cmt_inst",  64'(cmt_inst),     64'(h.inst));
    check("cmt_rd",    64'(cmt_rd),       64'(h.rd));
    check("cmt_wen",   64'(cmt_rd_wen),   64'(h.wen));
    check("cmt_nocmt", 64'(cmt_nocmt),    64'(h.nocmt));
    check("cmt_skip",  64'(cmt_skipcmt),  64'(h.skipcmt));
    check("halted",    64'(halted),       64'(m_st == 2));
    check("instr_cnt", instr_cnt,         m_instr);
    check("cycle_cnt", cycle_cnt,         m_cycles);
    check("hang",      64'(hang),         64'(m_hang));
  endtask

  task automatic apply(input bit req, input bit ack, input bit halt);
    wb_req      = req;
    cmt_ack     = ack;
    halt_req    = halt;
    wb_rd       = cur.rd;
    wb_rd_wen   = cur.wen;
    wb_rd_wdata = cur.wdata;
    wb_pc       = cur.pc;
    wb_inst     = cur.inst;
    wb_nocmt    = cur.nocmt;
    wb_skipcmt  = cur.skipcmt;
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.rd      = 5'($urandom);
    r.wen     = 1'($urandom);
    r.wdata   = {$urandom, $urandom};
    r.pc      = {$urandom, $urandom};
    r.inst    = $urandom;
    r.nocmt   = ($urandom_range(0, 3) == 0);
    r.skipcmt = ($urandom_range(0, 3) == 0);
    return r;
  endfunction

  // One clock: predict the edge from pre-edge model state and current inputs.
  task automatic cycle();
    int unsigned sz;
    bit push, pop, counted;
    int st;
    sz      = q.size();
    st      = m_st;
    push    = wb_req && (st == 0) && (sz < DEPTH);
    pop     = (sz != 0) && cmt_ack;
    counted = pop ? !q[0].nocmt : 1'b0;
    @(posedge clk);
    #1;
    if (pop) q.delete(0);
    if (push) q.push_back(cur);
    m_pushed = push;
    if (counted) m_instr++;
    if (st != 2) m_cycles++;
    if (counted) m_idle = 0;
    else if (st != 2 && m_idle < WD_SAT) m_idle++;
    if (m_idle >= TIMEOUT - 1) m_hang = 1'b1;
    if (st == 0 && halt_req) m_st = 1;
    else if (st == 1 && sz == 0) m_st = 2;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q.delete();
    m_st = 0; m_instr = 0; m_cycles = 0; m_idle = 0; m_hang = 1'b0; m_pushed = 1'b0;
    #1;
    compare();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Random traffic; an unaccepted record is held until taken, as writeback would.
  task automatic random_run(input int segs, input int len);
    for (int s = 0; s < segs; s++) begin
      int req_pct, ack_pct;
      req_pct = $urandom_range(10, 95);
      ack_pct = $urandom_range(5, 100);
      for (int i = 0; i < len; i++) begin
        bit r;
        if (!(wb_req && !m_pushed)) begin
          r = ($urandom_range(0, 99) < req_pct);
          if (r) cur = rand_rec();
        end else begin
          r = 1'b1;
        end
        apply(r, $urandom_range(0, 99) < ack_pct, 1'b0);
        cycle();
      end
    end
  endtask

  task automatic drain_to_halt();
    for (int i = 0; i < 100 && m_st != 2; i++) begin
      cur = rand_rec();
      apply($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0);
      cycle();
    end
    check("halted_reached", 64'(halted), 64'd1);
    for (int i = 0; i < 8; i++) begin
      cur = rand_rec();
      apply($urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 1) == 1);
      cycle();
    end
  endtask

  initial begin
    cur = '0;
    apply(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    do_reset();

    // Single record with downstream always ready.
    cur = '0; cur.pc = 64'h8000_0000; cur.inst = 32'h0000_0013; cur.rd = 5'd1; cur.wen = 1'b1;
    apply(1'b1, 1'b1, 1'b0); cycle();
    apply(1'b0, 1'b1, 1'b0); cycle(); cycle();

    // Fill with downstream stalled, fifth record held until a slot frees.
    for (int i = 0; i < 5; i++) begin
      cur = rand_rec(); cur.nocmt = 1'b0; cur.pc = 64'h1000 + 64'(4 * i);
      apply(1'b1, 1'b0, 1'b0);
      cycle();
      if (i < 4) check("fill_accept", 64'(m_pushed), 64'd1);
    end
    apply(1'b1, 1'b0, 1'b0); cycle(); cycle();
    for (int i = 0; i < 6; i++) begin
      apply(!m_pushed && wb_req, 1'b1, 1'b0);
      cycle();
    end

    // Alternating bubbles, all flagged skip.
    for (int i = 0; i < 6; i++) begin
      cur = rand_rec(); cur.nocmt = (i % 2 == 0); cur.skipcmt = 1'b1;
      apply(1'b1, 1'b1, 1'b0);
      cycle();
    end
    apply(1'b0, 1'b1, 1'b0);
    repeat (4) cycle();

    random_run(6, 40);

    // Halt with two queued and a concurrent push.
    apply(1'b0, 1'b1, 1'b0);
    repeat (6) cycle();
    for (int i = 0; i < 2; i++) begin
      cur = rand_rec(); apply(1'b1, 1'b0, 1'b0); cycle();
    end
    cur = rand_rec(); apply(1'b1, 1'b0, 1'b1); cycle();
    drain_to_halt();

    // Reset out of HALTED, then an idle stretch for the watchdog.
    #2;
    do_reset();
    apply(1'b0, 1'b0, 1'b0);
    repeat (20) cycle();
    random_run(4, 40);

    // Reset in the middle of a stalled drain.
    for (int i = 0; i < 6; i++) begin
      cur = rand_rec(); apply(1'b1, 1'b0, 1'b0); cycle();
    end
    apply(1'b0, 1'b0, 1'b1); cycle();
    apply(1'b0, 1'b0, 1'b0);
    repeat (3) cycle();
    #2;
    do_reset();

    // Halt with an empty FIFO.
    apply(1'b0, 1'b0, 1'b1); cycle();
    apply(1'b0, 1'b0, 1'b0); cycle(); cycle();
    drain_to_halt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
